// File: rtl/cache_flush_pkg.sv
// Shared types and helpers for the cache flush sequencer.
package cache_flush_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CHECK   = 3'd2,
    WB      = 3'd3,
    ADVANCE = 3'd4,
    DONE    = 3'd5
  } flush_state_t;

  localparam int unsigned MAXWAYS = 64;
  localparam int unsigned WAYIDXW = $clog2(MAXWAYS);

  // Rotate the low numWays bits of a one-hot way vector left by one, top way wrapping to way 0.
  function automatic logic [MAXWAYS-1:0] rotateWayLeft(input logic [MAXWAYS-1:0] way,
                                                       input int unsigned numWays);
    logic [MAXWAYS-1:0] rotated;
    rotated = '0;
    for (int unsigned i = 0; i < MAXWAYS; i++) begin
      if (i < numWays) begin
        rotated[WAYIDXW'(i)] = (i == 0) ? way[WAYIDXW'(numWays - 1)] : way[WAYIDXW'(i - 1)];
      end
    end
    return rotated;
  endfunction

endpackage

// File: rtl/cache_flush_ctrl_if.sv
// Flush request / cache-array / writeback signals between the cache and its flush sequencer.
interface cache_flush_ctrl_if #(
  parameter int unsigned NUMWAYS = 4,
  parameter int unsigned NUMSETS = 128,
  parameter int unsigned SETLEN  = $clog2(NUMSETS)
);
  logic               FlushReq;
  logic               FlushStage;
  logic               LineDirty;
  logic               WbAck;
  logic [SETLEN-1:0]  FlushAdr;
  logic [NUMWAYS-1:0] FlushWay;
  logic               FlushBusy;
  logic               WbReq;
  logic               ClearDirty;
  logic               InvalidateCache;
  logic               FlushDone;

  // Cache / requester side.
  modport master (
    output FlushReq, FlushStage, LineDirty, WbAck,
    input  FlushAdr, FlushWay, FlushBusy, WbReq, ClearDirty, InvalidateCache, FlushDone
  );

  // Flush sequencer side.
  modport slave (
    input  FlushReq, FlushStage, LineDirty, WbAck,
    output FlushAdr, FlushWay, FlushBusy, WbReq, ClearDirty, InvalidateCache, FlushDone
  );
endinterface

// File: rtl/flush_line_counter.sv
// Set counter and one-hot way register walked way-inner, set-outer by the flush sequencer.
module flush_line_counter
  import cache_flush_pkg::*;
#(
  parameter int unsigned NUMWAYS = 4,
  parameter int unsigned NUMSETS = 128,
  parameter int unsigned SETLEN  = $clog2(NUMSETS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               advance,
  output logic [SETLEN-1:0]  FlushAdr,
  output logic [NUMWAYS-1:0] FlushWay,
  output logic               LastLine
);

  // The sequencer never advances past the last line, so the set counter cannot wrap.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      FlushAdr <= '0;
      FlushWay <= NUMWAYS'(1);
    end else if (advance) begin
      FlushWay <= NUMWAYS'(rotateWayLeft(MAXWAYS'(FlushWay), NUMWAYS));
      if (FlushWay[NUMWAYS-1]) begin
        FlushAdr <= FlushAdr + SETLEN'(1);
      end
    end
  end

  assign LastLine = FlushWay[NUMWAYS-1] & (FlushAdr == SETLEN'(NUMSETS - 1));

endmodule

// File: rtl/cache_flush_ctrl.sv
// Cache flush sequencer: walks every (set, way), writes back dirty lines and clears their dirty bits.
// Optional CACHE_FLUSH_INVALIDATE_EN adds an InvalidateCache pulse alongside FlushDone.
module cache_flush_ctrl
  import cache_flush_pkg::*;
#(
  parameter int unsigned NUMWAYS = 4,
  parameter int unsigned NUMSETS = 128,
  parameter int unsigned SETLEN  = $clog2(NUMSETS)
) (
  input logic               clk,
  input logic               reset,
  cache_flush_ctrl_if.slave flushBus
);

  flush_state_t       state;
  flush_state_t       nextState;
  logic               advanceLine;
  logic               clearLine;
  logic               clearDirty;
  logic               lastLine;
  logic [SETLEN-1:0]  setIdx;
  logic [NUMWAYS-1:0] wayOneHot;
  logic               busyQ;
  logic               wbReqQ;
  logic               doneQ;

  flush_line_counter #(
    .NUMWAYS (NUMWAYS),
    .NUMSETS (NUMSETS),
    .SETLEN  (SETLEN)
  ) lineCounter (
    .clk      (clk),
    .reset    (reset),
    .clear    (clearLine),
    .advance  (advanceLine),
    .FlushAdr (setIdx),
    .FlushWay (wayOneHot),
    .LastLine (lastLine)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next state, counter control and the ack-cycle dirty-bit clear.
  always_comb begin
    nextState   = state;
    advanceLine = 1'b0;
    clearLine   = 1'b0;
    clearDirty  = 1'b0;
    unique case (state)
      IDLE:    if (flushBus.FlushReq && !flushBus.FlushStage) nextState = READ;
      READ:    nextState = CHECK;
      CHECK:   nextState = flushBus.LineDirty ? WB : ADVANCE;
      WB: begin
        if (flushBus.WbAck) begin
          clearDirty = 1'b1;
          nextState  = ADVANCE;
        end
      end
      ADVANCE: begin
        if (lastLine) begin
          clearLine = 1'b1;
          nextState = DONE;
        end else begin
          advanceLine = 1'b1;
          nextState   = READ;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      busyQ  <= 1'b0;
      wbReqQ <= 1'b0;
      doneQ  <= 1'b0;
    end else begin
      busyQ  <= (nextState != IDLE);
      wbReqQ <= (nextState == WB);
      doneQ  <= (nextState == DONE);
    end
  end

`ifdef CACHE_FLUSH_INVALIDATE_EN
  logic invalidateQ;

  always_ff @(posedge clk) begin
    if (reset) begin
      invalidateQ <= 1'b0;
    end else begin
      invalidateQ <= (nextState == DONE);
    end
  end

  assign flushBus.InvalidateCache = invalidateQ;
`else
  assign flushBus.InvalidateCache = 1'b0;
`endif

  assign flushBus.FlushAdr   = setIdx;
  assign flushBus.FlushWay   = wayOneHot;
  assign flushBus.FlushBusy  = busyQ;
  assign flushBus.WbReq      = wbReqQ;
  assign flushBus.ClearDirty = clearDirty;
  assign flushBus.FlushDone  = doneQ;

endmodule

// File: tb/tb_cache_flush_ctrl.sv
// Self-checking bench for cache_flush_ctrl with a 4-set, 2-way cache.
module tb_cache_flush_ctrl;

  localparam int unsigned NWAYS = 2;
  localparam int unsigned NSETS = 4;
  localparam int unsigned NLINES = NWAYS * NSETS;

  typedef struct {
    logic       rst;
    logic       req;
    logic       stage;
    logic       dirty;
    logic       ack;
    logic [1:0] adr;
    logic [1:0] way;
    logic       busy;
    logic       wbReq;
    logic       clr;
    logic       inv;
    logic       done;
  } vec_t;

  logic clk;
  logic reset;

  vec_t vecs[$];
  vec_t expQ[$];
  int   nApplied;
  int   nFail;

  cache_flush_ctrl_if #(.NUMWAYS(NWAYS), .NUMSETS(NSETS)) bus ();

  cache_flush_ctrl #(
    .NUMWAYS (NWAYS),
    .NUMSETS (NSETS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flushBus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One record describes one clock cycle: inputs driven in it and outputs expected during it.
  task automatic addVec(input logic rst, input logic req, input logic stage, input logic dirty,
                        input logic ack, input logic [1:0] adr, input logic [1:0] way,
                        input logic busy, input logic wbReq, input logic clr, input logic done);
    vec_t v;
    v.rst   = rst;
    v.req   = req;
    v.stage = stage;
    v.dirty = dirty;
    v.ack   = ack;
    v.adr   = adr;
    v.way   = way;
    v.busy  = busy;
    v.wbReq = wbReq;
    v.clr   = clr;
    v.done  = done;
`ifdef CACHE_FLUSH_INVALIDATE_EN
    v.inv   = done;
`else
    v.inv   = 1'b0;
`endif
    vecs.push_back(v);
  endtask

  task automatic addIdle(input logic req, input logic stage);
    addVec(1'b0, req, stage, 1'b0, 1'b0, 2'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Cycles from the first READ through DONE for one full walk; dirtyLine < 0 means all clean.
  task automatic addWalk(input int dirtyLine, input int ackDelay, input logic req,
                         input logic stage, input logic strayAck);
    for (int k = 0; k < int'(NLINES); k++) begin
      logic [1:0] a;
      logic [1:0] w;
      a = 2'(k / 2);
      w = (k % 2 == 1) ? 2'b10 : 2'b01;
      addVec(1'b0, req, stage, 1'b0, 1'b0, a, w, 1'b1, 1'b0, 1'b0, 1'b0);
      if (k == dirtyLine) begin
        addVec(1'b0, req, stage, 1'b1, 1'b0, a, w, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j <= ackDelay; j++) begin
          addVec(1'b0, req, stage, 1'b0, (j == ackDelay), a, w, 1'b1, 1'b1, (j == ackDelay), 1'b0);
        end
      end else begin
        addVec(1'b0, req, stage, 1'b0, strayAck, a, w, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      addVec(1'b0, req, stage, 1'b0, 1'b0, a, w, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    addVec(1'b0, req, stage, 1'b0, 1'b0, 2'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic checkCycle(input int idx);
    vec_t e;
    logic [8:0] act;
    logic [8:0] req;
    e = expQ.pop_front();
    act = {bus.FlushAdr, bus.FlushWay, bus.FlushBusy, bus.WbReq, bus.ClearDirty,
           bus.InvalidateCache, bus.FlushDone};
    req = {e.adr, e.way, e.busy, e.wbReq, e.clr, e.inv, e.done};
    nApplied++;
    if (act !== req) begin
      nFail++;
      $display("FAIL cycle%0d adr/way/busy/wbReq/clr/inv/done: got %b_%b_%b%b%b%b%b want %b_%b_%b%b%b%b%b",
               idx, act[8:7], act[6:5], act[4], act[3], act[2], act[1], act[0],
               req[8:7], req[6:5], req[4], req[3], req[2], req[1], req[0]);
    end
  endtask

  initial begin
    nApplied = 0;
    nFail    = 0;

    // Post-reset idle state.
    addIdle(1'b0, 1'b0);
    addIdle(1'b0, 1'b0);

    // Clean walk: accept at cycle 0, FlushDone 25 cycles later.
    addIdle(1'b1, 1'b0);
    addWalk(-1, 0, 1'b0, 1'b0, 1'b0);
    addIdle(1'b0, 1'b0);

    // Dirty line at set 2 way 1, acked 4 cycles after WbReq rises.
    addIdle(1'b1, 1'b0);
    addWalk(5, 4, 1'b0, 1'b0, 1'b0);
    addIdle(1'b0, 1'b0);

    // FlushStage holds off the start; FlushStage during the walk is ignored.
    addIdle(1'b1, 1'b1);
    addIdle(1'b1, 1'b1);
    addIdle(1'b1, 1'b1);
    addIdle(1'b1, 1'b0);
    addWalk(-1, 0, 1'b0, 1'b1, 1'b0);
    addIdle(1'b0, 1'b0);

    // Reset while waiting in WB aborts the walk; a new request restarts at set 0.
    addIdle(1'b1, 1'b0);
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    addVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    addIdle(1'b0, 1'b0);
    addIdle(1'b1, 1'b0);
    addWalk(-1, 0, 1'b0, 1'b0, 1'b0);
    addIdle(1'b0, 1'b0);

    // FlushReq held through FlushDone with stray WbAck in CHECK; second walk follows.
    addIdle(1'b1, 1'b0);
    addWalk(-1, 0, 1'b1, 1'b0, 1'b1);
    addIdle(1'b1, 1'b0);
    addWalk(-1, 0, 1'b0, 1'b0, 1'b0);
    addIdle(1'b0, 1'b0);
    addIdle(1'b0, 1'b0);

    reset          = 1'b1;
    bus.FlushReq   = 1'b0;
    bus.FlushStage = 1'b0;
    bus.LineDirty  = 1'b0;
    bus.WbAck      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      reset          = vecs[i].rst;
      bus.FlushReq   = vecs[i].req;
      bus.FlushStage = vecs[i].stage;
      bus.LineDirty  = vecs[i].dirty;
      bus.WbAck      = vecs[i].ack;
      expQ.push_back(vecs[i]);
      @(negedge clk);
      checkCycle(i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nFail);
    $finish;
  end

endmodule
